// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN output path.
package cnn_pkg;

    localparam int LANES         = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/psum_out_fifo.sv
// First-word fall-through FIFO for requantized output beats.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module psum_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign ovf_o   = push_i & full_o & ~do_pop;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) begin
                rd_q <= nxt(rd_q);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates 4-lane psums over NUM_CH passes, requantizes, streams out.
// Define PSUM_RELU_EN to clamp negative results to zero before output.
module psum_accumulator
    import cnn_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int NUM_PIX    = 16,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       in_psum0,
    input  logic [WIDTH-1:0]       in_psum1,
    input  logic [WIDTH-1:0]       in_psum2,
    input  logic [WIDTH-1:0]       in_psum3,
    input  logic                   in_psum_vld,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   tile_done,
    output logic                   busy,
    output logic                   err
);

    localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_e state_q, state_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           err_q, err_d;
    logic           done_q;

    logic                   beat;
    logic                   last_pix;
    logic                   last_ch;
    logic                   push;
    logic                   pop;
    logic                   ovf;
    logic                   f_full;
    logic                   f_empty;
    logic [FCW-1:0]         f_cnt;
    logic [LANES*WIDTH-1:0] push_data;
    logic [WIDTH-1:0]       psum [LANES];

    assign psum[0] = in_psum0;
    assign psum[1] = in_psum1;
    assign psum[2] = in_psum2;
    assign psum[3] = in_psum3;

    assign beat     = in_psum_vld & (state_q == ST_RUN);
    assign last_pix = (pix_q == PW'(NUM_PIX - 1));
    assign last_ch  = (ch_q == CHW'(NUM_CH - 1));
    assign push     = beat & last_ch;
    assign pop      = out_vld & out_rdy;

    // Pass 0 overwrites, middle passes add, the final pass only reads.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] acc_q [NUM_PIX];
        logic signed [ACC_WIDTH-1:0] ext;
        logic signed [ACC_WIDTH-1:0] base;
        logic signed [ACC_WIDTH-1:0] sum;
        logic signed [ACC_WIDTH-1:0] shr;
        logic signed [WIDTH-1:0]     sat;

        assign ext  = {{(ACC_WIDTH-WIDTH){psum[l][WIDTH-1]}}, psum[l]};
        assign base = (ch_q == '0) ? '0 : acc_q[pix_q];
        assign sum  = base + ext;
        assign shr  = sum >>> SHIFT;

        always_comb begin
            sat = shr[WIDTH-1:0];
            if (shr > SAT_MAX) begin
                sat = {1'b0, {(WIDTH-1){1'b1}}};
            end else if (shr < SAT_MIN) begin
                sat = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end

`ifdef PSUM_RELU_EN
        assign push_data[l*WIDTH +: WIDTH] = sat[WIDTH-1] ? '0 : sat;
`else
        assign push_data[l*WIDTH +: WIDTH] = sat;
`endif

        always_ff @(posedge clk) begin
            if (beat && !last_ch) begin
                acc_q[pix_q] <= sum;
            end
        end
    end

    psum_out_fifo #(
        .DW    (LANES*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (out_data),
        .full_o      (f_full),
        .empty_o     (f_empty),
        .ovf_o       (ovf),
        .count_o     (f_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave DRAIN on the edge of the final pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (beat && last_pix && last_ch) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (f_empty || (f_cnt == FCW'(1) && pop)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_vld   = ~f_empty;
        tile_done = done_q;
        err       = err_q;
    end

    always_comb begin
        pix_d = pix_q;
        ch_d  = ch_q;
        if (state_q == ST_IDLE && start) begin
            pix_d = '0;
            ch_d  = '0;
        end else if (beat) begin
            if (last_pix) begin
                pix_d = '0;
                ch_d  = last_ch ? '0 : ch_q + 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) err_d = 1'b0;
        if (state_q != ST_RUN && in_psum_vld) err_d = 1'b1;
        if (ovf) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q  <= '0;
            ch_q   <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pix_q  <= pix_d;
            ch_q   <= ch_d;
            err_q  <= err_d;
            done_q <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        end
    end

    logic unused_full;
    assign unused_full = f_full;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: two configurations side by side.
// u_d0: NUM_CH=2 NUM_PIX=4 SHIFT=0; u_d1: NUM_CH=2 NUM_PIX=6 SHIFT=4.
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start [2];
    logic              vld   [2];
    logic              rdy   [2];
    logic signed [7:0] ps    [2][4];
    logic [31:0]       odata [2];
    logic              ovld  [2];
    logic              done  [2];
    logic              busy  [2];
    logic              err   [2];

    psum_accumulator #(
        .WIDTH(8), .ACC_WIDTH(20), .NUM_CH(2),
        .NUM_PIX(4), .SHIFT(0), .FIFO_DEPTH(4)
    ) u_d0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .in_psum0(ps[0][0]), .in_psum1(ps[0][1]),
        .in_psum2(ps[0][2]), .in_psum3(ps[0][3]),
        .in_psum_vld(vld[0]), .out_data(odata[0]),
        .out_vld(ovld[0]), .out_rdy(rdy[0]),
        .tile_done(done[0]), .busy(busy[0]), .err(err[0])
    );

    psum_accumulator #(
        .WIDTH(8), .ACC_WIDTH(20), .NUM_CH(2),
        .NUM_PIX(6), .SHIFT(4), .FIFO_DEPTH(4)
    ) u_d1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .in_psum0(ps[1][0]), .in_psum1(ps[1][1]),
        .in_psum2(ps[1][2]), .in_psum3(ps[1][3]),
        .in_psum_vld(vld[1]), .out_data(odata[1]),
        .out_vld(ovld[1]), .out_rdy(rdy[1]),
        .tile_done(done[1]), .busy(busy[1]), .err(err[1])
    );

    typedef struct {
        logic signed [7:0] a [4];
        logic signed [7:0] b [4];
        int                e [4];
    } vec_t;

    typedef struct {
        int          d;
        logic [31:0] data;
    } obs_t;

    vec_t vt [14];
    obs_t oq [$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   done_cnt [2];
    int   done_cyc [2];
    int   pop_cyc  [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (ovld[d] && rdy[d]) begin
                    oq.push_back('{d, odata[d]});
                    pop_cyc[d] = cyc;
                end
                if (done[d]) begin
                    done_cnt[d] = done_cnt[d] + 1;
                    done_cyc[d] = cyc;
                end
            end
        end
    end

    function automatic int relu(input int x);
`ifdef PSUM_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] pk(input int i);
        logic [31:0] r;
        int v;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            v = relu(vt[i].e[l]);
            r[l*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic sv(input int i,
                      input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3,
                      input int e0, input int e1, input int e2, input int e3);
        vt[i].a[0] = 8'(a0); vt[i].a[1] = 8'(a1);
        vt[i].a[2] = 8'(a2); vt[i].a[3] = 8'(a3);
        vt[i].b[0] = 8'(b0); vt[i].b[1] = 8'(b1);
        vt[i].b[2] = 8'(b2); vt[i].b[3] = 8'(b3);
        vt[i].e[0] = e0; vt[i].e[1] = e1;
        vt[i].e[2] = e2; vt[i].e[3] = e3;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_tile(input int d, input int off, input int npix,
                              input bit rdy_fin, input bit mid_start);
        oq.delete();
        done_cnt[d] = 0;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int p = 0; p < npix; p++) begin
                if (ch == 1 && !rdy_fin) rdy[d] = 1'b0;
                start[d] = mid_start && ch == 0 && p == 2;
                for (int l = 0; l < 4; l++) begin
                    ps[d][l] = (ch == 1) ? vt[off+p].b[l] : vt[off+p].a[l];
                end
                vld[d] = 1'b1;
                tick();
            end
        end
        vld[d] = 1'b0;
        start[d] = 1'b0;
        for (int l = 0; l < 4; l++) ps[d][l] = '0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 100; i++) begin
            if (done_cnt[d] != 0) break;
            tick();
        end
        repeat (4) tick();
        chk("done_once", done_cnt[d], 1);
        chk("done_lat", done_cyc[d] - pop_cyc[d], 1);
        chk("busy_end", {31'b0, busy[d]}, 0);
    endtask

    task automatic check_out(input int d, input int off, input int n);
        chk("n_out", oq.size(), n);
        for (int i = 0; i < oq.size() && i < n; i++) begin
            chk("out_dut", oq[i].d, d);
            chk("out_data", oq[i].data, pk(off + i));
        end
    endtask

    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // tile A / tile B on u_d0 (SHIFT=0)
        sv(0,    3,    3,   3,   3,    5,    5,   5,   5,    8,    8,   8,    8);
        sv(1,  100, -100,   0,  -1,  100, -100,   0,  -1,  127, -128,   0,   -2);
        sv(2,  127, -128,  64, -64,    0,    0,  63, -64,  127, -128, 127, -128);
        sv(3,   -5,   10, -20,  30,    7,   -3,  25, -40,    2,    7,   5,  -10);
        sv(4,    1,    2,   3,   4,   10,   20,  30,  40,   11,   22,  33,   44);
        sv(5,   -1,   -2,  -3,  -4,  -10,  -20, -30, -40,  -11,  -22, -33,  -44);
        sv(6,  127,  127, 127, 127,  127,  127, 127, 127,  127,  127, 127,  127);
        sv(7,    0,    0,   0,   0, -128, -128,-128,-128, -128, -128,-128, -128);
        // shift tile on u_d1 (SHIFT=4)
        sv(8,  127, -127, 127,-127,  127, -127, 127,-127,   15,  -16,  15,  -16);
        sv(9,    8,   -8,  16,  -1,    8,   -9,  15,   0,    1,   -2,   1,   -1);
        sv(10, 127,  127,-128,-128,  127,  127,-128,-128,   15,   15, -16,  -16);
        sv(11,   0,    1,  15,  16,    0,    0,   0,   0,    0,    0,   0,    1);
        sv(12,  -1,  -16, -17,  32,    0,    0,   0,   0,   -1,   -1,  -2,    2);
        sv(13, 100,  100, 100, 100,  100, -100,  28, -28,   12,    0,   8,    4);

        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            vld[d] = 1'b0;
            rdy[d] = 1'b1;
            done_cnt[d] = 0;
            done_cyc[d] = 0;
            pop_cyc[d] = 0;
            for (int l = 0; l < 4; l++) ps[d][l] = '0;
        end
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_vld", {31'b0, ovld[0]}, 0);
        chk("rst_data", odata[0], 0);
        chk("rst_done", {31'b0, done[0]}, 0);
        chk("rst_busy", {31'b0, busy[0]}, 0);
        chk("rst_err", {31'b0, err[0]}, 0);
        chk("rst_busy1", {31'b0, busy[1]}, 0);
        rst = 1'b1;
        tick();

        // basic accumulation, saturation, channel-0 overwrite
        drive_tile(0, 0, 4, 1'b1, 1'b0);
        wait_done(0);
        check_out(0, 0, 4);
        chk("err_a", {31'b0, err[0]}, 0);
        drive_tile(0, 4, 4, 1'b1, 1'b0);
        wait_done(0);
        check_out(0, 4, 4);

        // arithmetic shift with floor rounding
        drive_tile(1, 8, 6, 1'b1, 1'b0);
        wait_done(1);
        check_out(1, 8, 6);
        chk("err_shift", {31'b0, err[1]}, 0);

        // backpressure: FIFO exactly fills, head held stable
        drive_tile(0, 0, 4, 1'b0, 1'b0);
        tick();
        tick();
        chk("bp_vld", {31'b0, ovld[0]}, 1);
        chk("bp_head", odata[0], pk(0));
        chk("bp_err", {31'b0, err[0]}, 0);
        held = odata[0];
        repeat (3) tick();
        chk("bp_stable", odata[0], held);
        chk("bp_busy", {31'b0, busy[0]}, 1);
        chk("bp_none", oq.size(), 0);
        rdy[0] = 1'b1;
        wait_done(0);
        check_out(0, 0, 4);

        // overflow: 6 final beats into a 4-deep FIFO
        drive_tile(1, 8, 6, 1'b0, 1'b0);
        tick();
        tick();
        chk("ovf_err", {31'b0, err[1]}, 1);
        chk("ovf_vld", {31'b0, ovld[1]}, 1);
        rdy[1] = 1'b1;
        wait_done(1);
        check_out(1, 8, 4);
        chk("ovf_sticky", {31'b0, err[1]}, 1);

        // protocol: beat in IDLE, start clears err, start in RUN ignored
        oq.delete();
        for (int l = 0; l < 4; l++) ps[0][l] = 8'sd9;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int l = 0; l < 4; l++) ps[0][l] = '0;
        tick();
        chk("idle_err", {31'b0, err[0]}, 1);
        repeat (2) tick();
        chk("idle_nout", oq.size(), 0);
        chk("idle_vld", {31'b0, ovld[0]}, 0);
        chk("idle_busy", {31'b0, busy[0]}, 0);
        drive_tile(0, 0, 4, 1'b1, 1'b1);
        wait_done(0);
        check_out(0, 0, 4);
        chk("start_clr", {31'b0, err[0]}, 0);

        // reset in the middle of RUN, then a clean tile
        oq.delete();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int l = 0; l < 4; l++) ps[0][l] = vt[1+p].a[l];
            vld[0] = 1'b1;
            tick();
        end
        vld[0] = 1'b0;
        for (int l = 0; l < 4; l++) ps[0][l] = '0;
        chk("pre_rst_busy", {31'b0, busy[0]}, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy[0]}, 0);
        chk("mid_rst_vld", {31'b0, ovld[0]}, 0);
        tick();
        rst = 1'b1;
        tick();
        drive_tile(0, 4, 4, 1'b1, 1'b0);
        wait_done(0);
        check_out(0, 4, 4);
        chk("post_rst_err", {31'b0, err[0]}, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
